// File: rtl/ram_arbiter.sv
// Two-requester round-robin arbiter in front of a single-port RAM with a fixed
// read latency. Moore FSM: every output is a flop or a decode of registered state.
module ram_arbiter #(
    parameter int MEM_WIDTH = 16,
    parameter int ADDR_SIZE = 10,
    parameter int RD_LAT    = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_a,
    input  logic                 req_b,
    input  logic                 we_a,
    input  logic                 we_b,
    input  logic [ADDR_SIZE-1:0] addr_a,
    input  logic [ADDR_SIZE-1:0] addr_b,
    input  logic [MEM_WIDTH-1:0] wdata_a,
    input  logic [MEM_WIDTH-1:0] wdata_b,
    output logic                 gnt_a,
    output logic                 gnt_b,
    output logic                 rvalid_a,
    output logic                 rvalid_b,
    output logic [MEM_WIDTH-1:0] rdata,
    output logic                 rpar,
    output logic                 busy,
    output logic [MEM_WIDTH-1:0] ram_din,
    output logic [ADDR_SIZE-1:0] ram_addr,
    output logic                 ram_wr_en,
    output logic                 ram_rd_en,
    output logic                 ram_blk_select,
    output logic                 ram_addr_en,
    output logic                 ram_dout_en,
    input  logic [MEM_WIDTH-1:0] ram_dout,
    input  logic                 ram_parity_out
);

    typedef enum logic [1:0] {IDLE, ISSUE, RDWAIT, RESP} state_t;
    typedef enum logic {OWN_A = 1'b0, OWN_B = 1'b1} owner_t;

    localparam logic [2:0] LAST_CNT = 3'(RD_LAT - 1);

    state_t               state_q, state_d;
    owner_t               owner_q, owner_d;
    owner_t               last_q, last_d;
    logic                 we_q, we_d;
    logic [ADDR_SIZE-1:0] addr_q, addr_d;
    logic [MEM_WIDTH-1:0] wdata_q, wdata_d;
    logic [2:0]           cnt_q, cnt_d;
    logic [MEM_WIDTH-1:0] rdata_q, rdata_d;
    logic                 rpar_q, rpar_d;

    logic gnt_a_q, gnt_a_d, gnt_b_q, gnt_b_d;
    logic rvalid_a_q, rvalid_a_d, rvalid_b_q, rvalid_b_d;
    logic busy_q, busy_d;
    logic wr_en_q, wr_en_d, rd_en_q, rd_en_d;
    logic blk_q, blk_d, addr_en_q, addr_en_d, dout_en_q, dout_en_d;

    owner_t pick;
    logic   issue_nxt, wait_nxt;

    // B wins only when A is absent or A was the last one served.
    always_comb begin
        if (req_b && (!req_a || last_q == OWN_A)) pick = OWN_B;
        else                                      pick = OWN_A;
    end

    always_comb begin
        // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latch).
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        rpar_d  = rpar_q;

        case (state_q)
            IDLE: begin
                if (req_a || req_b) begin
                    owner_d = pick;
                    last_d  = pick;
                    we_d    = (pick == OWN_B) ? we_b    : we_a;
                    addr_d  = (pick == OWN_B) ? addr_b  : addr_a;
                    wdata_d = (pick == OWN_B) ? wdata_b : wdata_a;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (we_q) begin
                    state_d = IDLE;
                end else begin
                    state_d = RDWAIT;
                    cnt_d   = '0;
                end
            end
            RDWAIT: begin
                if (cnt_q == LAST_CNT) begin
                    rdata_d = ram_dout;
                    rpar_d  = ram_parity_out;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Outputs are registered copies of the decode of the next state,
        // so they line up with the state they belong to.
        issue_nxt  = (state_d == ISSUE);
        wait_nxt   = (state_d == RDWAIT);
        gnt_a_d    = issue_nxt && (owner_d == OWN_A);
        gnt_b_d    = issue_nxt && (owner_d == OWN_B);
        rvalid_a_d = (state_d == RESP) && (owner_d == OWN_A);
        rvalid_b_d = (state_d == RESP) && (owner_d == OWN_B);
        busy_d     = (state_d != IDLE);
        wr_en_d    = issue_nxt && we_d;
        rd_en_d    = issue_nxt && !we_d;
        blk_d      = issue_nxt || wait_nxt;
        addr_en_d  = issue_nxt;
        dout_en_d  = wait_nxt;
    end

    // NOTE: sequential state uses non-blocking assignments only; all next values come from the comb block.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: reset is asynchronous, so an access in flight is dropped immediately.
            state_q    <= IDLE;
            owner_q    <= OWN_A;
            last_q     <= OWN_B;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            cnt_q      <= '0;
            rdata_q    <= '0;
            rpar_q     <= 1'b0;
            gnt_a_q    <= 1'b0;
            gnt_b_q    <= 1'b0;
            rvalid_a_q <= 1'b0;
            rvalid_b_q <= 1'b0;
            busy_q     <= 1'b0;
            wr_en_q    <= 1'b0;
            rd_en_q    <= 1'b0;
            blk_q      <= 1'b0;
            addr_en_q  <= 1'b0;
            dout_en_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            last_q     <= last_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            cnt_q      <= cnt_d;
            rdata_q    <= rdata_d;
            rpar_q     <= rpar_d;
            gnt_a_q    <= gnt_a_d;
            gnt_b_q    <= gnt_b_d;
            rvalid_a_q <= rvalid_a_d;
            rvalid_b_q <= rvalid_b_d;
            busy_q     <= busy_d;
            wr_en_q    <= wr_en_d;
            rd_en_q    <= rd_en_d;
            blk_q      <= blk_d;
            addr_en_q  <= addr_en_d;
            dout_en_q  <= dout_en_d;
        end
    end

    // Address and write data stay on the RAM pins between accesses.
    assign ram_addr       = addr_q;
    assign ram_din        = wdata_q;
    assign rdata          = rdata_q;
    assign rpar           = rpar_q;
    assign gnt_a          = gnt_a_q;
    assign gnt_b          = gnt_b_q;
    assign rvalid_a       = rvalid_a_q;
    assign rvalid_b       = rvalid_b_q;
    assign busy           = busy_q;
    assign ram_wr_en      = wr_en_q;
    assign ram_rd_en      = rd_en_q;
    assign ram_blk_select = blk_q;
    assign ram_addr_en    = addr_en_q;
    assign ram_dout_en    = dout_en_q;

endmodule
